// File: rtl/mem_responder.sv
// Byte-organised little-endian memory slave with a fixed wait-state latency.
// Accepts one request at a time; store commit and load capture happen on the edge entering RESP.
module mem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        RESP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        accept, enter_resp, commit;

    logic        we_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;

    logic        t_we, t_uns, t_err;
    logic [31:0] t_addr, t_wdata, ld_data;
    logic [1:0]  t_size;

    logic [ADDR_W-1:0] idx, base;
    logic [7:0]  b0, b1, b2, b3;

    logic [7:0]  mem [2**ADDR_W];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && (state == IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAITING;
                        cnt_nxt   = 3'(WAIT - 1);
                    end
                end
            end
            WAITING: begin
                if (cnt == 3'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 3'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With WAIT=0 the RESP-entry edge is the acceptance edge, so take the live inputs then.
    always_comb begin
        if (state == IDLE) begin
            t_we    = req_we;
            t_addr  = req_addr;
            t_wdata = req_wdata;
            t_size  = req_size;
            t_uns   = req_unsigned;
        end else begin
            t_we    = we_q;
            t_addr  = addr_q;
            t_wdata = wdata_q;
            t_size  = size_q;
            t_uns   = uns_q;
        end
    end

    assign t_err = (t_size == 2'b11)
                || ((t_size == 2'b01) && t_addr[0])
                || ((t_size == 2'b10) && (t_addr[1:0] != 2'b00))
                || ((t_addr >> ADDR_W) != '0);

    assign idx = t_addr[ADDR_W-1:0];

    always_comb begin
        case (t_size)
            2'b00:   base = idx;
            2'b01:   base = {idx[ADDR_W-1:1], 1'b0};
            default: base = {idx[ADDR_W-1:2], 2'b00};
        endcase
    end

    assign b0 = mem[base];
    assign b1 = mem[base + ADDR_W'(1)];
    assign b2 = mem[base + ADDR_W'(2)];
    assign b3 = mem[base + ADDR_W'(3)];

    always_comb begin
        case (t_size)
            2'b00:   ld_data = {{24{b0[7] & ~t_uns}}, b0};
            2'b01:   ld_data = {{16{b1[7] & ~t_uns}}, b1, b0};
            default: ld_data = {b3, b2, b1, b0};
        endcase
        if (t_err || t_we) ld_data = '0;
    end

    assign enter_resp = (state_nxt == RESP);
    assign commit     = enter_resp && !rst && t_we && !t_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                resp_rdata <= ld_data;
                resp_err   <= t_err;
            end else begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            case (t_size)
                2'b00: mem[base] <= t_wdata[7:0];
                2'b01: begin
                    mem[base]               <= t_wdata[7:0];
                    mem[base + ADDR_W'(1)]  <= t_wdata[15:8];
                end
                default: begin
                    mem[base]               <= t_wdata[7:0];
                    mem[base + ADDR_W'(1)]  <= t_wdata[15:8];
                    mem[base + ADDR_W'(2)]  <= t_wdata[23:16];
                    mem[base + ADDR_W'(3)]  <= t_wdata[31:24];
                end
            endcase
        end
    end

endmodule
